// File: rtl/bullet_engine.sv
// bullet_engine: single-bullet attack pattern generator for the fight phase.
// Spawns bullets from an LFSR, moves them once per video frame, detects
// overlap with the player heart and emits one-cycle hit/heal pulses.
module bullet_engine #(
    parameter int          MAXC        = 200,
    parameter int          SPEED       = 4,
    parameter int          NUM_BULLETS = 8,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          HIT_SMALL   = 16,
    parameter int          HIT_BLUE    = 58
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        start,
    input  logic [15:0] player_pos,
    output logic [15:0] bullet_pos,
    output logic [1:0]  bullet_color,
    output logic        is_render,
    output logic        hit,
    output logic        heal,
    output logic        busy,
    output logic        done
);
    localparam logic [7:0] L_MAXC = 8'(MAXC);
    localparam logic [4:0] L_SPD  = 5'(SPEED);
    localparam logic [4:0] L_NSPD = 5'(-SPEED);
    localparam logic [7:0] L_NB   = 8'(NUM_BULLETS);
    localparam logic [7:0] L_HS   = 8'(HIT_SMALL);
    localparam logic [7:0] L_HB   = 8'(HIT_BLUE);

    typedef enum logic [1:0] {S_IDLE, S_SPAWN, S_MOVE, S_DONE} state_t;

    // Fibonacci LFSR step, taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Unsigned absolute difference of two coordinates
    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    state_t      r_state, w_state_nxt;
    logic        r_vs_d1, r_vs_d2, w_ft;
    logic [15:0] r_lfsr, r_ppos;
    logic [7:0]  r_bx, r_by, w_bx_nxt, w_by_nxt;
    logic [4:0]  r_vx, r_vy, w_vx_nxt, w_vy_nxt;
    logic [1:0]  r_color, w_color_nxt;
    logic        r_render, r_hit, r_heal, r_busy, r_done;
    logic        w_render_nxt, w_hit_nxt, w_heal_nxt, w_busy_nxt, w_done_nxt;
    logic [7:0]  r_count, w_count_nxt, w_cnt_inc;
    logic [7:0]  w_perp, w_sp_bx, w_sp_by, w_lim;
    logic [4:0]  w_pv, w_sp_vx, w_sp_vy;
    logic [1:0]  w_sp_col;
    logic [8:0]  w_nx, w_ny;
    logic        w_out, w_overlap, w_moved, w_pulse_hit, w_pulse_heal, w_despawn;

    // Frame tick: one clk wide, the cycle after vsync is first sampled high
    assign w_ft = r_vs_d1 & ~r_vs_d2;

    // Spawn parameters derived from the current LFSR value
    assign w_perp   = {2'b00, r_lfsr[13:8]} + 8'd68;
    assign w_pv     = r_lfsr[2] ? 5'd1 : 5'h1F;
    assign w_sp_col = r_lfsr[4] ? (r_lfsr[3] ? 2'd2 : 2'd1) : 2'd0;

    // Overlap test against the live heart position
    assign w_lim        = (r_color == 2'd2) ? L_HB : L_HS;
    assign w_overlap    = (abs_diff(r_bx, player_pos[15:8]) <= w_lim) &&
                          (abs_diff(r_by, player_pos[7:0]) <= w_lim);
    assign w_moved      = (player_pos != r_ppos);
    assign w_pulse_hit  = w_overlap && ((r_color == 2'd0) || ((r_color == 2'd2) && w_moved));
    assign w_pulse_heal = w_overlap && (r_color == 2'd1);

    // Next position in 9-bit two's complement; bit 8 set means negative
    assign w_nx  = {1'b0, r_bx} + {{4{r_vx[4]}}, r_vx};
    assign w_ny  = {1'b0, r_by} + {{4{r_vy[4]}}, r_vy};
    assign w_out = w_nx[8] | w_ny[8] | (w_nx[7:0] > L_MAXC) | (w_ny[7:0] > L_MAXC);

    assign w_cnt_inc = r_count + 8'd1;

    // Entry edge and velocities chosen by the LFSR side field
    always_comb begin
        w_sp_bx = 8'd0;
        w_sp_by = 8'd0;
        w_sp_vx = 5'd0;
        w_sp_vy = 5'd0;
        case (r_lfsr[1:0])
            2'd0:    begin w_sp_bx = 8'd0;   w_sp_by = w_perp; w_sp_vx = L_SPD;  w_sp_vy = w_pv;   end
            2'd1:    begin w_sp_bx = L_MAXC; w_sp_by = w_perp; w_sp_vx = L_NSPD; w_sp_vy = w_pv;   end
            2'd2:    begin w_sp_bx = w_perp; w_sp_by = 8'd0;   w_sp_vx = w_pv;   w_sp_vy = L_SPD;  end
            2'd3:    begin w_sp_bx = w_perp; w_sp_by = L_MAXC; w_sp_vx = w_pv;   w_sp_vy = L_NSPD; end
            default: begin w_sp_bx = 8'd0;   w_sp_by = 8'd0;   w_sp_vx = 5'd0;   w_sp_vy = 5'd0;   end
        endcase
    end

    // Attack FSM next-state and datapath next values
    always_comb begin
        w_state_nxt  = r_state;
        w_bx_nxt     = r_bx;
        w_by_nxt     = r_by;
        w_vx_nxt     = r_vx;
        w_vy_nxt     = r_vy;
        w_color_nxt  = r_color;
        w_render_nxt = r_render;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;
        w_count_nxt  = r_count;
        w_hit_nxt    = 1'b0;
        w_heal_nxt   = 1'b0;
        w_despawn    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_SPAWN;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_count_nxt = 8'd0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_SPAWN: begin
                if (w_ft) begin
                    w_bx_nxt     = w_sp_bx;
                    w_by_nxt     = w_sp_by;
                    w_vx_nxt     = w_sp_vx;
                    w_vy_nxt     = w_sp_vy;
                    w_color_nxt  = w_sp_col;
                    w_render_nxt = 1'b1;
                    w_state_nxt  = S_MOVE;
                end else begin
                    w_state_nxt = S_SPAWN;
                end
            end
            S_MOVE: begin
                if (w_ft) begin
                    if (w_pulse_hit || w_pulse_heal) begin
                        w_hit_nxt  = w_pulse_hit;
                        w_heal_nxt = w_pulse_heal;
                        w_despawn  = 1'b1;
                    end else if (w_out) begin
                        w_despawn = 1'b1;
                    end else begin
                        w_bx_nxt = w_nx[7:0];
                        w_by_nxt = w_ny[7:0];
                    end
                    if (w_despawn) begin
                        w_render_nxt = 1'b0;
                        w_count_nxt  = w_cnt_inc;
                        if (w_cnt_inc == L_NB) begin
                            w_state_nxt = S_DONE;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_SPAWN;
                        end
                    end else begin
                        w_state_nxt = S_MOVE;
                    end
                end else begin
                    w_state_nxt = S_MOVE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_render_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
                w_done_nxt   = 1'b0;
            end
        endcase
    end

    // State, LFSR, vsync history, player latch and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_vs_d1  <= 1'b0;
            r_vs_d2  <= 1'b0;
            r_lfsr   <= SEED;
            r_ppos   <= 16'd0;
            r_bx     <= 8'd0;
            r_by     <= 8'd0;
            r_vx     <= 5'd0;
            r_vy     <= 5'd0;
            r_color  <= 2'd0;
            r_render <= 1'b0;
            r_hit    <= 1'b0;
            r_heal   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_vs_d1  <= vsync;
            r_vs_d2  <= r_vs_d1;
            r_lfsr   <= lfsr_next(r_lfsr);
            r_ppos   <= w_ft ? player_pos : r_ppos;
            r_bx     <= w_bx_nxt;
            r_by     <= w_by_nxt;
            r_vx     <= w_vx_nxt;
            r_vy     <= w_vy_nxt;
            r_color  <= w_color_nxt;
            r_render <= w_render_nxt;
            r_hit    <= w_hit_nxt;
            r_heal   <= w_heal_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_count  <= w_count_nxt;
        end
    end

    assign bullet_pos   = {r_bx, r_by};
    assign bullet_color = r_color;
    assign is_render    = r_render;
    assign hit          = r_hit;
    assign heal         = r_heal;
    assign busy         = r_busy;
    assign done         = r_done;
endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine (two bullets per attack).
module tb_bullet_engine;
    logic        clk = 1'b0;
    logic        reset, vsync, start;
    logic [15:0] player_pos;
    logic [15:0] bullet_pos;
    logic [1:0]  bullet_color;
    logic        is_render, hit, heal, busy, done;

    bullet_engine #(.NUM_BULLETS(2)) u_dut (
        .clk(clk), .reset(reset), .vsync(vsync), .start(start),
        .player_pos(player_pos), .bullet_pos(bullet_pos),
        .bullet_color(bullet_color), .is_render(is_render),
        .hit(hit), .heal(heal), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lf_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference LFSR running alongside the DUT
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= lf_next(m_lfsr);
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected spawn state for LFSR value L (SPEED=4, MAXC=200)
    function automatic void dec(input logic [15:0] L, output int x, output int y,
                                output int vx, output int vy, output logic [1:0] c);
        int p  = int'(L[13:8]) + 68;
        int pv = L[2] ? 1 : -1;
        case (L[1:0])
            2'd0:    begin x = 0;   y = p;   vx = 4;  vy = pv; end
            2'd1:    begin x = 200; y = p;   vx = -4; vy = pv; end
            2'd2:    begin x = p;   y = 0;   vx = pv; vy = 4;  end
            default: begin x = p;   y = 200; vx = pv; vy = -4; end
        endcase
        c = (L[4:3] == 2'b11) ? 2'd2 : ((L[4:3] == 2'b10) ? 2'd1 : 2'd0);
    endfunction

    logic [15:0] s_pos, t_L;
    logic [1:0]  s_col;
    logic        s_ren, s_hit, s_heal, s_busy, s_done, s_hit2, s_heal2;

    // One frame: vsync pulse, sample just after the ft edge and one clk later
    task automatic tick();
        t_L   = lf_next(m_lfsr);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        s_pos = bullet_pos; s_col = bullet_color; s_ren = is_render;
        s_hit = hit; s_heal = heal; s_busy = busy; s_done = done;
        @(negedge clk);
        s_hit2 = hit; s_heal2 = heal;
    endtask

    // Delay the next frame until the LFSR value used at its ft matches val under mask
    task automatic tick_target(input logic [15:0] mask, input logic [15:0] val);
        int n = 0;
        while (((lf_next(m_lfsr) & mask) != val) && (n < 20000)) begin
            @(negedge clk);
            n++;
        end
        chk("lfsr_search", 32'(n < 20000), 32'd1);
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follow one bullet from its spawn frame to the frame it is expected to vanish
    task automatic run_bullet(input string nm, input logic [15:0] L, input int kind,
                              input int nft, input int start_at);
        int x, y, vx, vy;
        logic [1:0] c;
        dec(L, x, y, vx, vy, c);
        chk($sformatf("%s_spawn", nm), {s_ren, s_col, s_pos}, {1'b1, c, x[7:0], y[7:0]});
        for (int k = 1; k <= nft; k++) begin
            if (k == start_at) pulse_start();
            tick();
            if (k < nft) begin
                chk($sformatf("%s_move%0d", nm, k), {s_ren, s_hit, s_heal, s_pos},
                    {1'b1, 1'b0, 1'b0, 8'(x + k * vx), 8'(y + k * vy)});
            end else begin
                chk($sformatf("%s_end%0d", nm, k), {s_ren, s_hit, s_heal, s_hit2, s_heal2},
                    {1'b0, kind == 1, kind == 2, 1'b0, 1'b0});
            end
        end
    endtask

    typedef struct {
        logic [1:0]  side;
        logic [5:0]  perp;
        logic [1:0]  col;
        logic [15:0] ppos;
        int          kind;   // 0 none, 1 hit, 2 heal
        int          nft;    // move frames until the bullet vanishes
    } rec_t;

    rec_t tbl [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int x, y, vx, vy;
        logic [1:0] c;
        logic [15:0] l2;

        tbl[0] = '{2'd0, 6'd32, 2'b00, {8'd20,  8'd100}, 1, 2};
        tbl[1] = '{2'd0, 6'd32, 2'b10, {8'd20,  8'd100}, 2, 2};
        tbl[2] = '{2'd1, 6'd32, 2'b00, {8'd180, 8'd100}, 1, 2};
        tbl[3] = '{2'd2, 6'd32, 2'b00, {8'd100, 8'd20},  1, 2};
        tbl[4] = '{2'd3, 6'd32, 2'b10, {8'd100, 8'd180}, 2, 2};
        tbl[5] = '{2'd0, 6'd32, 2'b00, {8'd100, 8'd0},   0, 51};
        tbl[6] = '{2'd0, 6'd32, 2'b11, {8'd20,  8'd100}, 0, 51};
        tbl[7] = '{2'd1, 6'd0,  2'b00, {8'd0,   8'd0},   0, 51};
        tbl[8] = '{2'd2, 6'd63, 2'b10, {8'd0,   8'd0},   0, 51};

        reset = 1'b1; vsync = 1'b0; start = 1'b0; player_pos = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {bullet_pos, bullet_color, is_render, hit, heal, busy, done}, 32'd0);
        chk("reset_lfsr", u_dut.r_lfsr, 32'h0000ACE1);
        reset = 1'b0;

        // Idle frames without start
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle%0d", i), {s_ren, s_busy, s_done, s_hit, s_heal, s_hit2, s_heal2}, 32'd0);
        end
        chk("idle_lfsr", u_dut.r_lfsr, m_lfsr);

        // Table of targeted first bullets; second bullet runs out harmlessly
        for (int i = 0; i < 9; i++) begin
            player_pos = tbl[i].ppos;
            tick();
            tick();
            pulse_start();
            chk($sformatf("t%0d_busy", i), {busy, done}, 32'd2);
            tick_target(16'h3F1B, {2'b00, tbl[i].perp, 3'b000, tbl[i].col, 1'b0, tbl[i].side});
            run_bullet($sformatf("t%0d_b1", i), t_L, tbl[i].kind, tbl[i].nft, 0);
            chk($sformatf("t%0d_count", i), {u_dut.r_count, busy, done}, {8'd1, 1'b1, 1'b0});
            player_pos = 16'd0;
            tick();
            run_bullet($sformatf("t%0d_b2", i), t_L, 0, 51, 0);
            chk($sformatf("t%0d_done", i), {busy, done, is_render}, 32'd2);
        end

        // Blue bullet: static heart is safe, a 1-pixel move is a hit
        player_pos = {8'd20, 8'd100};
        tick();
        pulse_start();
        tick_target(16'h3F1B, {2'b00, 6'd32, 3'b000, 2'b11, 1'b0, 2'd0});
        dec(t_L, x, y, vx, vy, c);
        chk("blue_spawn", {s_ren, s_col, s_pos}, {1'b1, c, x[7:0], y[7:0]});
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("blue_static%0d", k), {s_ren, s_hit, s_heal, s_pos},
                {1'b1, 1'b0, 1'b0, 8'(x + k * vx), 8'(y + k * vy)});
        end
        player_pos = {8'd21, 8'd100};
        tick();
        chk("blue_moved_hit", {s_ren, s_hit, s_heal, s_hit2}, {1'b0, 1'b1, 1'b0, 1'b0});

        // Second bullet: start while busy is ignored, then reset mid-move
        player_pos = 16'd0;
        tick();
        l2 = t_L;
        dec(l2, x, y, vx, vy, c);
        chk("b2_spawn", {s_ren, s_pos}, {1'b1, x[7:0], y[7:0]});
        tick();
        tick();
        pulse_start();
        tick();
        chk("busy_start_pos", {s_ren, s_pos}, {1'b1, 8'(x + 3 * vx), 8'(y + 3 * vy)});
        chk("busy_start_cnt", {u_dut.r_count, busy, done}, {8'd1, 1'b1, 1'b0});
        #2 reset = 1'b1;
        #1;
        chk("midreset_outs", {bullet_pos, bullet_color, is_render, hit, heal, busy, done}, 32'd0);
        chk("midreset_cnt", {u_dut.r_count, u_dut.r_lfsr}, 32'h0000ACE1);
        @(negedge clk);
        reset = 1'b0;

        // Full two-bullet attack from a fresh reset, heart at {100,0}
        player_pos = {8'd100, 8'd0};
        tick();
        pulse_start();
        chk("fa_cnt0", {u_dut.r_count, busy, done}, {8'd0, 1'b1, 1'b0});
        tick_target(16'h0002, 16'h0000);
        run_bullet("fa1", t_L, 0, 51, 0);
        chk("fa_mid", {u_dut.r_count, busy, done}, {8'd1, 1'b1, 1'b0});
        tick_target(16'h0002, 16'h0000);
        run_bullet("fa2", t_L, 0, 51, 20);
        chk("fa_done", {u_dut.r_count, busy, done, is_render}, {8'd2, 1'b0, 1'b1, 1'b0});
        tick();
        chk("fa_done_hold", {s_busy, s_done, s_ren, s_hit, s_heal}, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
